// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack with overflow/underflow pulses and a small set of
// checkpoint slots so fetch can snapshot before a branch and repair on mispredict.
module ras_ckpt_stack #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CKPT_N = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [ADDR_W-1:0]             push_addr,
  output logic [ADDR_W-1:0]             top,
  output logic                          top_valid,
  output logic [$clog2(DEPTH):0]        count,
  input  logic                          ckpt_save,
  input  logic [((CKPT_N > 1) ? $clog2(CKPT_N) : 1)-1:0] ckpt_wid,
  input  logic                          ckpt_restore,
  input  logic [((CKPT_N > 1) ? $clog2(CKPT_N) : 1)-1:0] ckpt_rid,
  input  logic                          flush,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              ck_valid_q [CKPT_N];
  logic [PW-1:0]     ck_ptr_q   [CKPT_N];
  logic [CW-1:0]     ck_cnt_q   [CKPT_N];
  logic [ADDR_W-1:0] ck_tos_q   [CKPT_N];

  logic              mem_we;
  logic [PW-1:0]     mem_waddr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              save_en;
  logic              ck_clr;
  logic              full;
  logic              restore_hit;

  assign full        = (cnt_q == CW'(DEPTH));
  assign restore_hit = ckpt_restore && ck_valid_q[ckpt_rid];

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = push_addr;
    save_en   = 1'b0;
    ck_clr    = 1'b0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    if (flush) begin
      ck_clr = 1'b1;
      ptr_d  = '0;
      cnt_d  = '0;
    end else if (restore_hit) begin
      ptr_d     = ck_ptr_q[ckpt_rid];
      cnt_d     = ck_cnt_q[ckpt_rid];
      mem_we    = 1'b1;
      mem_waddr = ck_ptr_q[ckpt_rid];
      mem_wdata = ck_tos_q[ckpt_rid];
    end else begin
      save_en = ckpt_save;
      if (push && pop) begin
        // Call-through-return: replace top in place; an empty stack gains one entry.
        mem_we = 1'b1;
        if (cnt_q == '0) cnt_d = CW'(1);
      end else if (push) begin
        ptr_d     = ptr_q + PW'(1);
        mem_we    = 1'b1;
        mem_waddr = ptr_q + PW'(1);
        cnt_d     = full ? cnt_q : cnt_q + CW'(1);
        ovf_d     = full;
      end else if (pop) begin
        if (cnt_q == '0) begin
          unf_d = 1'b1;
        end else begin
          ptr_d = ptr_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int unsigned j = 0; j < CKPT_N; j++) begin
        ck_valid_q[j] <= 1'b0;
        ck_ptr_q[j]   <= '0;
        ck_cnt_q[j]   <= '0;
        ck_tos_q[j]   <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
      if (ck_clr) begin
        for (int unsigned j = 0; j < CKPT_N; j++) ck_valid_q[j] <= 1'b0;
      end else if (save_en) begin
        // Snapshot reflects state before this cycle's push/pop.
        ck_valid_q[ckpt_wid] <= 1'b1;
        ck_ptr_q[ckpt_wid]   <= ptr_q;
        ck_cnt_q[ckpt_wid]   <= cnt_q;
        ck_tos_q[ckpt_wid]   <= mem_q[ptr_q];
      end
    end
  end

  assign top       = mem_q[ptr_q];
  assign top_valid = (cnt_q != '0);
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Directed scoreboard bench for ras_ckpt_stack: the driver queues the expected
// post-edge state for every cycle and a negedge monitor pops and compares it.
module tb_ras_ckpt_stack;

  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_PUSH  = 6'b000001;
  localparam logic [5:0] C_POP   = 6'b000010;
  localparam logic [5:0] C_SAVE  = 6'b000100;
  localparam logic [5:0] C_REST  = 6'b001000;
  localparam logic [5:0] C_FLUSH = 6'b010000;
  localparam logic [5:0] C_RST   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst, push, pop, ckpt_save, ckpt_restore, flush;
  logic [16:0] push_addr;
  logic [1:0]  ckpt_wid, ckpt_rid;
  logic [16:0] top;
  logic        top_valid, overflow, underflow;
  logic [4:0]  count;

  typedef struct {
    int          cyc;
    int          idx;
    logic [16:0] top;
    int          cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   nstep  = 0;
  int   checks = 0;
  int   errors = 0;

  ras_ckpt_stack #(.ADDR_W(17), .DEPTH(16), .CKPT_N(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .top(top), .top_valid(top_valid), .count(count),
    .ckpt_save(ckpt_save), .ckpt_wid(ckpt_wid),
    .ckpt_restore(ckpt_restore), .ckpt_rid(ckpt_rid),
    .flush(flush), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares each expectation on the negedge following its target edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        logic ev;
        e  = exp_q.pop_front();
        ev = (e.cnt != 0);
        checks++;
        if (e.cyc != cyc || top !== e.top || count !== 5'(e.cnt) || top_valid !== ev ||
            overflow !== e.ovf || underflow !== e.unf) begin
          errors++;
          $display("FAIL step%0d: got top=%h cnt=%0d tv=%b ovf=%b unf=%b, want top=%h cnt=%0d tv=%b ovf=%b unf=%b",
                   e.idx, top, count, top_valid, overflow, underflow,
                   e.top, e.cnt, ev, e.ovf, e.unf);
        end
      end
    end
  end

  task automatic step(input logic [5:0] ctl, input logic [16:0] a, input int w, input int r,
                      input logic [16:0] et, input int ec, input logic eo, input logic eu);
    exp_t e;
    logic [31:0] wv, rv;
    wv = w;
    rv = r;
    push         = ctl[0];
    pop          = ctl[1];
    ckpt_save    = ctl[2];
    ckpt_restore = ctl[3];
    flush        = ctl[4];
    rst          = ctl[5];
    push_addr    = a;
    ckpt_wid     = wv[1:0];
    ckpt_rid     = rv[1:0];
    e.cyc = cyc + 1;
    e.idx = nstep;
    e.top = et;
    e.cnt = ec;
    e.ovf = eo;
    e.unf = eu;
    exp_q.push_back(e);
    nstep++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    {rst, push, pop, ckpt_save, ckpt_restore, flush} = '0;
    push_addr = '0;
    ckpt_wid  = '0;
    ckpt_rid  = '0;
    @(posedge clk);
    #1;
    step(C_RST, 0, 0, 0, 17'h0, 0, 0, 0);
    step(C_RST, 0, 0, 0, 17'h0, 0, 0, 0);

    // Basic LIFO
    step(C_PUSH, 17'h100, 0, 0, 17'h100, 1, 0, 0);
    step(C_PUSH, 17'h200, 0, 0, 17'h200, 2, 0, 0);
    step(C_PUSH, 17'h300, 0, 0, 17'h300, 3, 0, 0);
    step(C_POP,  0, 0, 0, 17'h200, 2, 0, 0);
    step(C_POP,  0, 0, 0, 17'h100, 1, 0, 0);
    step(C_POP,  0, 0, 0, 17'h0,   0, 0, 0);

    // Fill past depth: 17th push overwrites the oldest and pulses overflow
    for (int i = 1; i <= 17; i++)
      step(C_PUSH, 17'(i), 0, 0, 17'(i), (i > 16) ? 16 : i, (i == 17), 0);
    for (int k = 1; k <= 15; k++)
      step(C_POP, 0, 0, 0, 17'(17 - k), 16 - k, 0, 0);
    step(C_POP, 0, 0, 0, 17'd17, 0, 0, 0);

    // Underflow leaves ptr alone
    step(C_POP,  0, 0, 0, 17'd17, 0, 0, 1);
    step(C_PUSH, 17'h5, 0, 0, 17'h5, 1, 0, 0);

    // Checkpoint save/restore
    step(C_FLUSH, 17'h55, 0, 0, 17'd16, 0, 0, 0);
    step(C_PUSH, 17'hA, 0, 0, 17'hA, 1, 0, 0);
    step(C_SAVE, 0, 1, 0, 17'hA, 1, 0, 0);
    step(C_POP,  0, 0, 0, 17'd16, 0, 0, 0);
    step(C_PUSH, 17'hB, 0, 0, 17'hB, 1, 0, 0);
    step(C_PUSH, 17'hC, 0, 0, 17'hC, 2, 0, 0);
    step(C_REST, 0, 0, 1, 17'hA, 1, 0, 0);
    step(C_REST | C_PUSH, 17'h77, 0, 1, 17'hA, 1, 0, 0);
    step(C_PUSH, 17'hD, 0, 0, 17'hD, 2, 0, 0);
    step(C_REST, 0, 0, 1, 17'hA, 1, 0, 0);
    step(C_REST | C_PUSH, 17'hE, 0, 2, 17'hE, 2, 0, 0);

    // Replace-top, and restore beats save in the same cycle
    step(C_POP,  0, 0, 0, 17'hA, 1, 0, 0);
    step(C_PUSH, 17'h20, 0, 0, 17'h20, 2, 0, 0);
    step(C_PUSH | C_POP, 17'h10, 0, 0, 17'h10, 2, 0, 0);
    step(C_SAVE | C_REST, 0, 0, 1, 17'hA, 1, 0, 0);
    step(C_REST | C_PUSH, 17'h33, 0, 0, 17'h33, 2, 0, 0);
    step(C_FLUSH, 0, 0, 0, 17'd16, 0, 0, 0);
    step(C_PUSH | C_POP, 17'h44, 0, 0, 17'h44, 1, 0, 0);
    step(C_FLUSH, 0, 0, 0, 17'h44, 0, 0, 0);
    step(C_REST | C_POP, 0, 0, 1, 17'h44, 0, 0, 1);
    step(C_POP | C_REST, 0, 0, 1, 17'h44, 0, 0, 1);
    step(C_PUSH, 17'h1, 0, 0, 17'h1, 1, 0, 0);
    step(C_POP, 0, 0, 0, 17'h44, 0, 0, 0);
    step(C_PUSH | C_POP, 17'h66, 0, 0, 17'h66, 1, 0, 0);
    step(C_POP, 0, 0, 0, 17'd15, 0, 0, 0);

    // Reset mid-sequence clears state and checkpoints
    for (int i = 1; i <= 5; i++) step(C_PUSH, 17'(i), 0, 0, 17'(i), i, 0, 0);
    step(C_SAVE, 0, 0, 0, 17'h5, 5, 0, 0);
    step(C_SAVE, 0, 2, 0, 17'h5, 5, 0, 0);
    step(C_RST | C_PUSH, 17'h99, 0, 0, 17'h0, 0, 0, 0);
    step(C_REST, 0, 0, 0, 17'h0, 0, 0, 0);
    step(C_REST | C_PUSH, 17'h7, 0, 2, 17'h7, 1, 0, 0);
    step(C_IDLE, 0, 0, 0, 17'h7, 1, 0, 0);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
